// File: rtl/sevenseg_readback_if.sv
//------------------------------------------------------------------------------
// sevenseg_readback_if : sampled display bus in, decoded frame and status out
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sevenseg_readback_if;
    logic       sample_en;
    logic [7:0] anodes;
    logic [6:0] cathodes;
    logic       clear_err;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       frame_valid;
    logic       anode_err;
    logic       stalled;

    modport master (
        output sample_en, anodes, cathodes, clear_err,
        input  digit0, digit1, digit2, digit3, frame_valid, anode_err, stalled
    );

    modport slave (
        input  sample_en, anodes, cathodes, clear_err,
        output digit0, digit1, digit2, digit3, frame_valid, anode_err, stalled
    );
endinterface

`default_nettype wire

// File: rtl/sevenseg_readback.sv
//------------------------------------------------------------------------------
// sevenseg_readback : filters a multiplexed 7-seg bus and rebuilds 4-digit frames
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sevenseg_readback #(
    parameter int STABLE_SAMPLES  = 4,
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    sevenseg_readback_if.slave bus
);

    localparam int              TW          = $clog2(TIMEOUT_SAMPLES + 1);
    localparam logic [3:0]      STABLE_MAX  = 4'(STABLE_SAMPLES);
    localparam logic [3:0]      STABLE_PRE  = 4'(STABLE_SAMPLES - 1);
    localparam logic [TW-1:0]   TIMEOUT_MAX = TW'(TIMEOUT_SAMPLES);

    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        logic [3:0] code;
        case (seg)
            7'h40:   code = 4'h0;
            7'h79:   code = 4'h1;
            7'h24:   code = 4'h2;
            7'h30:   code = 4'h3;
            7'h19:   code = 4'h4;
            7'h12:   code = 4'h5;
            7'h02:   code = 4'h6;
            7'h78:   code = 4'h7;
            7'h00:   code = 4'h8;
            7'h10:   code = 4'h9;
            7'h7F:   code = 4'hF;
            default: code = 4'hE;
        endcase
        return code;
    endfunction

    logic [14:0]   sample_q;
    logic [3:0]    stable_cnt;
    logic [3:0]    seen;
    logic [3:0]    shadow [4];
    logic [3:0]    digits [4];
    logic [TW-1:0] timeout_cnt;
    logic          stalled_q;
    logic          err_q;
    logic          frame_valid_q;

    logic [14:0]   sample_now;
    logic          is_idle;
    logic          one_low;
    logic          is_legal;
    logic          is_fault;
    logic          same_sample;
    logic [1:0]    active_idx;
    logic [3:0]    code_now;
    logic [3:0]    stable_next;
    logic [3:0]    seen_next;
    logic          capture;
    logic          frame_done;
    logic [TW-1:0] timeout_next;

    always_comb begin
        sample_now  = {bus.anodes, bus.cathodes};
        is_idle     = (bus.anodes == 8'hFF);
        active_idx  = 2'd0;
        one_low     = 1'b1;
        case (bus.anodes[3:0])
            4'hE:    active_idx = 2'd0;
            4'hD:    active_idx = 2'd1;
            4'hB:    active_idx = 2'd2;
            4'h7:    active_idx = 2'd3;
            default: one_low    = 1'b0;
        endcase
        is_legal    = one_low && (bus.anodes[7:4] == 4'hF);
        is_fault    = !is_idle && !is_legal;
        same_sample = (sample_now == sample_q);

        // Idle and faulted ticks both break the dwell, so the next legal run restarts at 1
        if (!is_legal) begin
            stable_next = 4'd0;
        end else if (!same_sample) begin
            stable_next = 4'd1;
        end else if (stable_cnt == STABLE_MAX) begin
            stable_next = stable_cnt;
        end else begin
            stable_next = stable_cnt + 4'd1;
        end

        capture    = bus.sample_en && is_legal && same_sample && (stable_cnt == STABLE_PRE);
        code_now   = seg_decode(bus.cathodes);
        seen_next  = seen | (4'b0001 << active_idx);
        frame_done = capture && (seen_next == 4'hF);

        if (capture) begin
            timeout_next = '0;
        end else if (timeout_cnt == TIMEOUT_MAX) begin
            timeout_next = timeout_cnt;
        end else begin
            timeout_next = timeout_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q      <= 15'h7FFF;
            stable_cnt    <= 4'd0;
            seen          <= 4'd0;
            timeout_cnt   <= '0;
            stalled_q     <= 1'b0;
            err_q         <= 1'b0;
            frame_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 4'hF;
                digits[i] <= 4'hF;
            end
        end else begin
            frame_valid_q <= frame_done;
            if (bus.sample_en) begin
                if (!is_fault) begin
                    sample_q <= sample_now;
                end
                stable_cnt  <= stable_next;
                timeout_cnt <= timeout_next;
                stalled_q   <= (timeout_next == TIMEOUT_MAX);
                if (is_fault) begin
                    err_q <= 1'b1;
                end else if (bus.clear_err) begin
                    err_q <= 1'b0;
                end
                if (capture) begin
                    shadow[active_idx] <= code_now;
                    seen               <= frame_done ? 4'h0 : seen_next;
                end
                // Completing digit comes straight from the decoder so all four load together
                if (frame_done) begin
                    for (int i = 0; i < 4; i++) begin
                        digits[i] <= (2'(i) == active_idx) ? code_now : shadow[i];
                    end
                end
            end
        end
    end

    assign bus.digit0      = digits[0];
    assign bus.digit1      = digits[1];
    assign bus.digit2      = digits[2];
    assign bus.digit3      = digits[3];
    assign bus.frame_valid = frame_valid_q;
    assign bus.anode_err   = err_q;
    assign bus.stalled     = stalled_q;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_readback.sv
//------------------------------------------------------------------------------
// tb_sevenseg_readback : scoreboard bench with a dwell-level reference model
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sevenseg_readback;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sevenseg_readback_if bus();

    sevenseg_readback #(
        .STABLE_SAMPLES (STABLE),
        .TIMEOUT_SAMPLES(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    logic [3:0]  m_shadow [4];
    logic [3:0]  m_seen;
    logic [15:0] m_frame;
    int          m_tcnt;
    bit          m_err;
    logic [14:0] m_last;
    bit          m_break;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [3:0] ref_decode(input logic [6:0] c);
        for (int k = 0; k < 11; k++)
            if (seg_of(k) == c) return (k == 10) ? 4'hF : 4'(k);
        return 4'hE;
    endfunction

    function automatic bit is_legal(input logic [7:0] a);
        logic [3:0] low_n;
        low_n = ~a[3:0];
        return (a[7:4] == 4'hF) && ($countones(low_n) == 1);
    endfunction

    function automatic int sat(input int v);
        return (v > TIMEOUT) ? TIMEOUT : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every frame_valid pulse must match the oldest expected frame
    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got %0h expected none",
                         {bus.digit3, bus.digit2, bus.digit1, bus.digit0});
            end else begin
                check("frame", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input logic [7:0] a, input logic [6:0] c, input bit clr);
        bus.anodes    = a;
        bus.cathodes  = c;
        bus.clear_err = clr;
        bus.sample_en = 1'b1;
        @(posedge clk); #1;
        bus.sample_en = 1'b0;
        bus.clear_err = 1'b0;
        repeat ($urandom_range(0, 1)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_stalled"}, bus.stalled, (m_tcnt >= TIMEOUT));
        check({tag, "_err"}, bus.anode_err, m_err);
        check({tag, "_digits"}, {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, m_frame);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_shadow[i] = 4'hF;
        m_seen  = 4'h0;
        m_frame = 16'hFFFF;
        m_tcnt  = 0;
        m_err   = 1'b0;
        m_break = 1'b1;
        m_last  = 15'h7FFF;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset         = 1'b1;
        bus.sample_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        check("reset_fv", bus.frame_valid, 1'b0);
        end_checks("reset");
    endtask

    task automatic idle_tick(input bit clr);
        tick(8'hFF, 7'h7F, clr);
        if (clr) m_err = 1'b0;
        m_tcnt  = sat(m_tcnt + 1);
        m_break = 1'b1;
    endtask

    task automatic fault_tick(input logic [7:0] a, input bit clr);
        tick(a, 7'($urandom), clr);
        m_err   = 1'b1;
        m_tcnt  = sat(m_tcnt + 1);
        m_break = 1'b1;
    endtask

    // One uninterrupted run of a legal sample: it captures iff it lasts STABLE ticks
    task automatic dwell(input int idx, input logic [6:0] pat, input int len);
        logic [7:0]  a;
        logic [14:0] s;
        a = {4'hF, 4'(~(4'b0001 << idx))};
        s = {a, pat};
        if (!m_break && s == m_last) idle_tick(1'b0);
        if (len >= STABLE) begin
            m_shadow[idx] = ref_decode(pat);
            m_seen[idx]   = 1'b1;
            if (m_seen == 4'hF) begin
                m_frame = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
                exp_q.push_back(m_frame);
                m_seen = 4'h0;
            end
            m_tcnt = sat(len - STABLE);
        end else begin
            m_tcnt = sat(m_tcnt + len);
        end
        repeat (len) tick(a, pat, 1'b0);
        m_last  = s;
        m_break = 1'b0;
        end_checks("dwell");
    endtask

    initial begin
        logic [7:0] fa;
        reset         = 1'b1;
        bus.sample_en = 1'b0;
        bus.anodes    = 8'hFF;
        bus.cathodes  = 7'h7F;
        bus.clear_err = 1'b0;
        model_reset();
        do_reset();

        // Scan 3,0,5,9 with full dwells
        dwell(0, seg_of(3), 6); dwell(1, seg_of(0), 6);
        dwell(2, seg_of(5), 6); dwell(3, seg_of(9), 6);

        // Too-short dwells until the scan is declared stalled, then recover
        repeat (86) begin
            dwell(0, seg_of(3), 3); dwell(1, seg_of(0), 3);
            dwell(2, seg_of(5), 3); dwell(3, seg_of(9), 3);
        end
        check("stalled_set", bus.stalled, 1'b1);
        dwell(0, seg_of(3), 6);
        check("stalled_clr", bus.stalled, 1'b0);

        // Bus fault is sticky and does not disturb frame capture
        fault_tick(8'hFC, 1'b0);
        end_checks("fault");
        dwell(1, seg_of(0), 6); dwell(2, seg_of(5), 6); dwell(3, seg_of(9), 6);
        idle_tick(1'b1);
        end_checks("clear");
        fault_tick(8'hFC, 1'b1);
        end_checks("clear_vs_fault");

        // Undecodable and blank patterns
        dwell(0, seg_of(4), 5); dwell(1, 7'h55, 5);
        dwell(2, seg_of(2), 5); dwell(3, 7'h7F, 5);

        // Reset mid-frame, then a clean scan
        dwell(0, seg_of(7), 6); dwell(1, seg_of(6), 6);
        do_reset();
        dwell(0, seg_of(1), 6); dwell(1, seg_of(2), 6);
        dwell(2, seg_of(3), 6); dwell(3, seg_of(4), 6);

        // Randomized mix of dwells, idles, faults and clears
        repeat (300) begin
            case ($urandom_range(0, 9))
                7: idle_tick(1'b0);
                8: begin
                    do fa = 8'($urandom); while (fa == 8'hFF || is_legal(fa));
                    fault_tick(fa, 1'($urandom));
                    end_checks("rnd_fault");
                end
                9: begin
                    idle_tick(1'b1);
                    end_checks("rnd_clear");
                end
                default: dwell($urandom_range(0, 3),
                               ($urandom_range(0, 4) == 0) ? 7'($urandom) : seg_of($urandom_range(0, 10)),
                               $urandom_range(1, 8));
            endcase
        end

        repeat (4) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sevenseg_readback.md
Name: sevenseg_readback

Overview:
- Receive-side counterpart of the quad seven-segment display driver.
- Samples the multiplexed anode/cathode bus, filters scan transitions and decodes segment patterns back to BCD digits.
- Publishes a coherent 4-digit frame with a one-cycle strobe, for on-chip self-check of the timer display path and for bench scoreboarding.
- Also flags bus faults and a stalled display scan.

Parameters:
- STABLE_SAMPLES, 4, consecutive identical samples required before a digit is captured (range 2..15).
- TIMEOUT_SAMPLES, 1024, sample_en ticks without any capture before stalled asserts (range 2..65535).

Ports:
- clk  in  1  system clock (5 MHz domain)
- reset  in  1  asynchronous, active-high; clears all state
- sample_en  in  1  single-cycle clock enable; bus is sampled only when high
- anodes  in  8  display anodes, active-low; bits [3:0] = digit0..digit3, bits [7:4] must stay high
- cathodes  in  7  segments, active-low; bit order {g,f,e,d,c,b,a}
- clear_err  in  1  synchronous clear of anode_err
- digit0..digit3  out  4 each  last complete frame; 0-9 BCD, 4'hF = blank, 4'hE = undecodable pattern
- frame_valid  out  1  one-cycle strobe when digit0..3 update
- anode_err  out  1  sticky bus fault
- stalled  out  1  no capture within TIMEOUT_SAMPLES ticks

Behaviour:
- Reset values: digit0..3 = 4'hF, frame_valid = 0, anode_err = 0, stalled = 0. Internal sample register = 15'h7FFF, stable_cnt = 0, seen mask = 0, timeout counter = 0.
- All state advances only when sample_en = 1. The exception is frame_valid, which deasserts on the next clk regardless.
- Sample classification, {anodes, cathodes} each tick:
  - Idle: anodes = 8'hFF. Resets stable_cnt to 0; no capture.
  - Legal: exactly one of anodes[3:0] low and anodes[7:4] = 4'hF.
  - Fault: anything else. Sets anode_err (sticky); sample is discarded and stable_cnt resets to 0.
- Stability filter:
  - A legal sample differing from the previous sample sets stable_cnt = 1.
  - An identical legal sample increments stable_cnt, saturating at STABLE_SAMPLES.
  - Capture happens on the tick stable_cnt becomes STABLE_SAMPLES; exactly one capture per dwell.
- Decode (cathodes, active-low → code):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 7F→F (blank).
  - Any other value → E.
- Capture writes the decoded code into the shadow slot for the active anode index and sets the matching seen-mask bit.
- Frame assembly:
  - When a capture makes seen = 4'b1111, digit0..3 load all four shadow slots atomically on the next clk edge and frame_valid pulses for that one cycle. seen then clears.
  - Re-capturing an already-seen index overwrites its shadow slot and does not complete a frame.
  - Outputs never mix two frames.
- Timeout:
  - Counter increments on each sample_en tick without a capture and clears on capture.
  - stalled asserts when the counter reaches TIMEOUT_SAMPLES and stays high (counter saturates).
  - stalled clears on the tick of the next capture.
- Simultaneous events:
  - clear_err coincident with a new fault leaves anode_err = 1 (set wins).
  - Capture and timeout on the same tick → capture wins; stalled stays/returns 0.
- Reset mid-frame discards shadow slots and the seen mask; the first post-reset frame needs four fresh captures.
- Latency: frame_valid rises 1 clk after the sample_en tick of the completing capture.

Test Plan:
- Reset → digit0..3 = F, frame_valid/anode_err/stalled = 0.
- Scan digits 3,0,5,9 (anodes E,D,B,7 with cathodes 30,40,12,10), each held 6 ticks → single frame_valid pulse; digit0..3 = 3,0,5,9.
- Same scan, each digit held only 3 ticks (STABLE_SAMPLES = 4) → no capture, no frame_valid. After 1024 ticks, stalled = 1; a subsequent 6-tick digit dwell clears stalled.
- anodes = 8'hFC for one tick → anode_err = 1; frame capture continues normally. clear_err pulse → 0; clear_err together with a fault → stays 1.
- cathodes = 7'h55 on digit1 plus blank 7F on digit3 → digit1 = E, digit3 = F in the completed frame.
- Reset asserted after 2 of 4 digits captured, then full scan 1,2,3,4 → exactly one frame_valid; digits 1,2,3,4, with no stale data.
